// File: rtl/os_generator_if.sv
// Start/Busy/Finish handshake and per-lane symbol bus between the TX LTSSM,
// the ordered-set generator and the TX mux.
interface os_generator_if #(
  parameter int LANESNUMBER = 16
);
  logic                       OSGeneratorStart;
  logic [2:0]                 OSType;
  logic [1:0]                 LaneNumber;
  logic [7:0]                 LinkNumber;
  logic [2:0]                 Rate;
  logic                       Loopback;
  logic                       OSGeneratorBusy;
  logic                       OSGeneratorFinish;
  logic [8*LANESNUMBER-1:0]   TxData;
  logic [LANESNUMBER-1:0]     TxDataK;
  logic                       TxDataValid;

  modport master (
    output OSGeneratorStart, OSType, LaneNumber, LinkNumber, Rate, Loopback,
    input  OSGeneratorBusy, OSGeneratorFinish, TxData, TxDataK, TxDataValid
  );

  modport slave (
    input  OSGeneratorStart, OSType, LaneNumber, LinkNumber, Rate, Loopback,
    output OSGeneratorBusy, OSGeneratorFinish, TxData, TxDataK, TxDataValid
  );
endinterface

// File: rtl/os_generator.sv
// Ordered-set generator: serialises one 16-symbol TS1/TS2/IDLE burst per
// accepted Start onto all lanes, one Gen1 symbol (data + K) per lane per Pclk.
module os_generator #(
  parameter int          LANESNUMBER = 16,
  parameter logic [7:0]  N_FTS       = 8'd255
) (
  input  logic            Pclk,
  input  logic            Reset,
  os_generator_if.slave   osIf
);

  typedef enum logic {ST_IDLE, ST_SEND} stateT;

  stateT                     state, stateNext;
  logic [3:0]                idx, idxNext;
  logic [2:0]                typeQ, typeNext;
  logic [1:0]                laneQ, laneNext;
  logic [7:0]                linkQ, linkNext;
  logic [2:0]                rateQ, rateNext;
  logic                      loopQ, loopNext;
  logic                      busyQ, busyNext;
  logic                      finishQ, finishNext;
  logic                      validQ, validNext;
  logic [8*LANESNUMBER-1:0]  dataQ, dataNext;
  logic [LANESNUMBER-1:0]    kQ, kNext;

  logic [2:0]                selType;
  logic [1:0]                selLane;
  logic [7:0]                selLink;
  logic [2:0]                selRate;
  logic                      selLoop;
  logic [3:0]                symIdx;
  logic                      emit;
  logic [8:0]                sym;

  // Returns {K, data} for one symbol of one lane.
  function automatic logic [8:0] symbolOf(
    input logic [2:0] osType,
    input logic [1:0] laneNum,
    input logic [7:0] linkNum,
    input logic [2:0] rate,
    input logic       loopback,
    input logic [3:0] s,
    input logic [7:0] lane
  );
    logic [8:0] r;
    r = '0;
    if (osType == 3'b000 || osType == 3'b001) begin
      case (s)
        4'd0:    r = {1'b1, 8'hBC};
        4'd1:    r = (linkNum == 8'd0) ? {1'b1, 8'hF7} : {1'b0, linkNum};
        4'd2:    r = (laneNum == 2'b01) ? {1'b0, lane} : {1'b1, 8'hF7};
        4'd3:    r = {1'b0, N_FTS};
        4'd4:    r = {1'b0, 2'b00, rate >= 3'd5, rate >= 3'd4, rate >= 3'd3,
                      rate >= 3'd2, 1'b1, 1'b0};
        4'd5:    r = {1'b0, 5'b00000, loopback, 2'b00};
        default: r = {1'b0, (osType == 3'b000) ? 8'h4A : 8'h45};
      endcase
    end
    return r;
  endfunction

  // Symbol 0 is built straight from the inputs because they are latched on
  // the same edge that drives it; later symbols come from the latched copy.
  always_comb begin
    selType = (state == ST_IDLE) ? osIf.OSType     : typeQ;
    selLane = (state == ST_IDLE) ? osIf.LaneNumber : laneQ;
    selLink = (state == ST_IDLE) ? osIf.LinkNumber : linkQ;
    selRate = (state == ST_IDLE) ? osIf.Rate       : rateQ;
    selLoop = (state == ST_IDLE) ? osIf.Loopback   : loopQ;
  end

  always_comb begin
    stateNext  = state;
    idxNext    = idx;
    typeNext   = typeQ;
    laneNext   = laneQ;
    linkNext   = linkQ;
    rateNext   = rateQ;
    loopNext   = loopQ;
    busyNext   = 1'b0;
    finishNext = 1'b0;
    validNext  = 1'b0;
    dataNext   = '0;
    kNext      = '0;
    symIdx     = '0;
    emit       = 1'b0;
    sym        = '0;

    unique case (state)
      ST_IDLE: begin
        if (osIf.OSGeneratorStart) begin
          typeNext  = osIf.OSType;
          laneNext  = osIf.LaneNumber;
          linkNext  = osIf.LinkNumber;
          rateNext  = osIf.Rate;
          loopNext  = osIf.Loopback;
          idxNext   = '0;
          symIdx    = '0;
          stateNext = ST_SEND;
          busyNext  = 1'b1;
          emit      = 1'b1;
        end
      end
      ST_SEND: begin
        symIdx  = idx + 4'd1;
        idxNext = symIdx;
        emit    = 1'b1;
        if (symIdx == 4'd15) begin
          finishNext = 1'b1;
          stateNext  = ST_IDLE;
        end else begin
          busyNext = 1'b1;
        end
      end
      default: stateNext = ST_IDLE;
    endcase

    if (emit) begin
      validNext = 1'b1;
      for (int unsigned i = 0; i < LANESNUMBER; i++) begin
        sym = symbolOf(selType, selLane, selLink, selRate, selLoop, symIdx, 8'(i));
        dataNext[8*i +: 8] = sym[7:0];
        kNext[i]           = sym[8];
      end
    end
  end

  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      typeQ   <= '0;
      laneQ   <= '0;
      linkQ   <= '0;
      rateQ   <= '0;
      loopQ   <= 1'b0;
      busyQ   <= 1'b0;
      finishQ <= 1'b0;
      validQ  <= 1'b0;
      dataQ   <= '0;
      kQ      <= '0;
    end else begin
      state   <= stateNext;
      idx     <= idxNext;
      typeQ   <= typeNext;
      laneQ   <= laneNext;
      linkQ   <= linkNext;
      rateQ   <= rateNext;
      loopQ   <= loopNext;
      busyQ   <= busyNext;
      finishQ <= finishNext;
      validQ  <= validNext;
      dataQ   <= dataNext;
      kQ      <= kNext;
    end
  end

  assign osIf.OSGeneratorBusy   = busyQ;
  assign osIf.OSGeneratorFinish = finishQ;
  assign osIf.TxDataValid       = validQ;
  assign osIf.TxData            = dataQ;
  assign osIf.TxDataK           = kQ;

endmodule

// File: tb/tb_os_generator.sv
// Directed bench for os_generator: TS1/TS2/IDLE bursts, back-to-back starts,
// mid-burst reset and the Rate ID sweep against hand-written symbol tables.
module tb_os_generator;

  logic Pclk;
  logic Reset;
  int unsigned checks;
  int unsigned errors;

  os_generator_if #(.LANESNUMBER(16)) osIf ();

  os_generator #(.LANESNUMBER(16), .N_FTS(8'd255)) dut (
    .Pclk  (Pclk),
    .Reset (Reset),
    .osIf  (osIf)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  localparam logic [127:0] SEQ_LANES = 128'h0F0E0D0C0B0A09080706050403020100;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idleCheck(input string tag);
    @(posedge Pclk); #1;
    check({tag, "_valid"},  128'(osIf.TxDataValid),       128'd0);
    check({tag, "_finish"}, 128'(osIf.OSGeneratorFinish), 128'd0);
    check({tag, "_busy"},   128'(osIf.OSGeneratorBusy),   128'd0);
    check({tag, "_data"},   osIf.TxData,                  128'd0);
    check({tag, "_k"},      128'(osIf.TxDataK),           128'd0);
  endtask

  // Start must already be applied; the first edge here is the accepting edge.
  task automatic checkBurst(input string tag, input logic [7:0] d [16],
                            input logic [15:0] kv, input logic seqLane,
                            input int unsigned changeAt, input logic [2:0] newType,
                            input logic keepStart);
    logic [127:0] expD;
    logic [127:0] expK;
    for (int unsigned k = 0; k < 16; k++) begin
      @(posedge Pclk); #1;
      expD = (k == 2 && seqLane) ? SEQ_LANES : {16{d[k]}};
      expK = kv[k] ? 128'hFFFF : 128'd0;
      check($sformatf("%s_s%0d_data", tag, k),   osIf.TxData,                  expD);
      check($sformatf("%s_s%0d_k", tag, k),      128'(osIf.TxDataK),           expK);
      check($sformatf("%s_s%0d_valid", tag, k),  128'(osIf.TxDataValid),       128'd1);
      check($sformatf("%s_s%0d_busy", tag, k),   128'(osIf.OSGeneratorBusy),   (k != 15) ? 128'd1 : 128'd0);
      check($sformatf("%s_s%0d_finish", tag, k), 128'(osIf.OSGeneratorFinish), (k == 15) ? 128'd1 : 128'd0);
      if (k == 0 && !keepStart) osIf.OSGeneratorStart = 1'b0;
      if (k == changeAt) osIf.OSType = newType;
    end
  endtask

  initial begin
    logic [7:0] tbl [16];
    logic [7:0] rateId [5];
    checks = 0;
    errors = 0;
    Reset = 1'b0;
    osIf.OSGeneratorStart = 1'b0;
    osIf.OSType     = 3'b000;
    osIf.LaneNumber = 2'b00;
    osIf.LinkNumber = 8'd0;
    osIf.Rate       = 3'd1;
    osIf.Loopback   = 1'b0;

    repeat (2) @(posedge Pclk);
    #1;
    check("rst_busy",   128'(osIf.OSGeneratorBusy),   128'd0);
    check("rst_finish", 128'(osIf.OSGeneratorFinish), 128'd0);
    check("rst_valid",  128'(osIf.TxDataValid),       128'd0);
    check("rst_data",   osIf.TxData,                  128'd0);
    check("rst_k",      128'(osIf.TxDataK),           128'd0);

    // Polling TS1; Start raised while still in reset is ignored on that edge.
    osIf.OSType = 3'b000; osIf.LinkNumber = 8'd0; osIf.LaneNumber = 2'b00;
    osIf.Rate = 3'd1; osIf.Loopback = 1'b1; osIf.OSGeneratorStart = 1'b1;
    @(posedge Pclk); #1;
    check("rststart_valid", 128'(osIf.TxDataValid),     128'd0);
    check("rststart_busy",  128'(osIf.OSGeneratorBusy), 128'd0);
    Reset = 1'b1;
    tbl = '{8'hBC, 8'hF7, 8'hF7, 8'hFF, 8'h02, 8'h04, 8'h4A, 8'h4A,
            8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A};
    checkBurst("ts1poll", tbl, 16'h0007, 1'b0, 16, 3'b000, 1'b0);
    idleCheck("ts1poll_end");

    // Config TS2 with sequential lane numbers.
    osIf.OSType = 3'b001; osIf.LinkNumber = 8'h01; osIf.LaneNumber = 2'b01;
    osIf.Rate = 3'd3; osIf.Loopback = 1'b0; osIf.OSGeneratorStart = 1'b1;
    tbl = '{8'hBC, 8'h01, 8'h00, 8'hFF, 8'h0E, 8'h00, 8'h45, 8'h45,
            8'h45, 8'h45, 8'h45, 8'h45, 8'h45, 8'h45, 8'h45, 8'h45};
    checkBurst("ts2cfg", tbl, 16'h0001, 1'b1, 16, 3'b000, 1'b0);
    idleCheck("ts2cfg_end");

    // IDLE and a reserved type that must also produce IDLE.
    tbl = '{default: 8'h00};
    osIf.OSType = 3'b100; osIf.OSGeneratorStart = 1'b1;
    checkBurst("idle100", tbl, 16'h0000, 1'b0, 16, 3'b000, 1'b0);
    idleCheck("idle100_end");
    osIf.OSType = 3'b111; osIf.OSGeneratorStart = 1'b1;
    checkBurst("idle111", tbl, 16'h0000, 1'b0, 16, 3'b000, 1'b0);
    idleCheck("idle111_end");

    // Start held high: contiguous bursts; OSType change mid-burst lands next burst.
    osIf.OSType = 3'b000; osIf.LinkNumber = 8'd0; osIf.LaneNumber = 2'b00;
    osIf.Rate = 3'd2; osIf.Loopback = 1'b0; osIf.OSGeneratorStart = 1'b1;
    tbl = '{8'hBC, 8'hF7, 8'hF7, 8'hFF, 8'h06, 8'h00, 8'h4A, 8'h4A,
            8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A};
    checkBurst("b2b_ts1", tbl, 16'h0007, 1'b0, 5, 3'b001, 1'b1);
    tbl = '{8'hBC, 8'hF7, 8'hF7, 8'hFF, 8'h06, 8'h00, 8'h45, 8'h45,
            8'h45, 8'h45, 8'h45, 8'h45, 8'h45, 8'h45, 8'h45, 8'h45};
    checkBurst("b2b_ts2", tbl, 16'h0007, 1'b0, 16, 3'b000, 1'b0);
    idleCheck("b2b_end");

    // Reset asserted after symbol 7 is on the wire.
    osIf.OSType = 3'b000; osIf.Rate = 3'd1; osIf.OSGeneratorStart = 1'b1;
    for (int unsigned k = 0; k < 8; k++) begin
      @(posedge Pclk); #1;
      osIf.OSGeneratorStart = 1'b0;
    end
    check("abort_s7_data", osIf.TxData, {16{8'h4A}});
    Reset = 1'b0;
    @(posedge Pclk); #1;
    check("abort_valid", 128'(osIf.TxDataValid),     128'd0);
    check("abort_busy",  128'(osIf.OSGeneratorBusy), 128'd0);
    check("abort_data",  osIf.TxData,                128'd0);
    for (int unsigned k = 0; k < 10; k++) begin
      @(posedge Pclk); #1;
      check($sformatf("abort_finish_%0d", k), 128'(osIf.OSGeneratorFinish), 128'd0);
    end
    Reset = 1'b1;
    idleCheck("abort_release");

    // Rate sweep: first burst after the aborted one must start at symbol 0.
    rateId = '{8'h02, 8'h06, 8'h0E, 8'h1E, 8'h3E};
    for (int unsigned r = 1; r <= 5; r++) begin
      tbl = '{8'hBC, 8'hF7, 8'hF7, 8'hFF, 8'h00, 8'h00, 8'h4A, 8'h4A,
              8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A};
      tbl[4] = rateId[r-1];
      osIf.OSType = 3'b000; osIf.Rate = 3'(r); osIf.Loopback = 1'b0;
      osIf.OSGeneratorStart = 1'b1;
      checkBurst($sformatf("rate%0d", r), tbl, 16'h0007, 1'b0, 16, 3'b000, 1'b0);
      idleCheck($sformatf("rate%0d_end", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/os_generator.md
# os_generator

Ordered-set generator for the transmit path. It sits directly downstream of the TX LTSSM and is started by it over a Start/Busy/Finish handshake. It serialises one 16-symbol TS1, TS2 or IDLE burst per request onto all lanes, one symbol per lane per Pclk, in Gen1 8b/10b symbol form (8-bit data plus K flag). Its output feeds the TX mux (ordered-set side) ahead of the PIPE.

## Interface
- LANESNUMBER, 16, number of lanes driven.
- N_FTS, 8'd255, value sent in symbol 3 of TS1/TS2.
- Pclk  input  1  PIPE clock; all logic on rising edge.
- Reset  input  1  synchronous, active-low.
- OSGeneratorStart  input  1  request; accepted only when OSGeneratorBusy=0.
- OSType  input  3  000 TS1, 001 TS2, 100 IDLE; any other code is treated as IDLE.
- LaneNumber  input  2  00 PAD, 01 sequential (lane i sends i); 10/11 treated as PAD.
- LinkNumber  input  8  0 means PAD; otherwise sent verbatim.
- Rate  input  3  highest supported generation, 1..5.
- Loopback  input  1  sets Loopback bit in training-control symbol.
- OSGeneratorBusy  output  1  high while a burst is in flight.
- OSGeneratorFinish  output  1  one-cycle pulse with the last symbol.
- TxData  output  8*LANESNUMBER  lane i at [8i+7:8i].
- TxDataK  output  LANESNUMBER  K flag per lane.
- TxDataValid  output  1  high when TxData carries a symbol.

## Operation
- Reset value of every output is 0. The internal symbol index is 0 and the latched fields are 0.
- States: IDLE and SEND. There is a 4-bit symbol index `idx`.
- IDLE: if Start=1, latch OSType, LaneNumber, LinkNumber, Rate and Loopback. Then go to SEND and drive symbol 0 at the same edge.
- IDLE with no Start: TxData, TxDataK and TxDataValid are 0.
- SEND: each edge drives symbol idx+1 and increments idx.
- When symbol 15 is driven, OSGeneratorFinish goes to 1 and OSGeneratorBusy goes to 0 at that edge. The next edge returns to IDLE.
- Start while Busy=1 is ignored, including in the Finish cycle (Busy is still 1 before that edge). Changes to the inputs while Busy=1 have no effect.
- TS1/TS2 symbol map (same on all lanes except symbol 2):
  - Symbol 0: COM, data BC, K=1.
  - Symbol 1: LinkNumber; if 0, PAD (F7, K=1).
  - Symbol 2: lane i sends i[7:0] with K=0 when LaneNumber=01; otherwise PAD (F7, K=1).
  - Symbol 3: N_FTS, K=0.
  - Symbol 4, Rate ID, K=0: bit1=1; bit2=(Rate≥2); bit3=(Rate≥3); bit4=(Rate≥4); bit5=(Rate≥5). All other bits are 0. Rate=0 is treated as 1.
  - Symbol 5, training control, K=0: bit2=Loopback, all other bits 0.
  - Symbols 6–15: TS identifier, K=0. TS1 sends 4A; TS2 sends 45.
- IDLE burst: 16 symbols of data 00, K=0, on all lanes.
- TxDataValid=1 for exactly the 16 cycles a burst occupies.

## Timing
- Start sampled 1 at edge T (with Busy=0 before that edge) gives this sequence:
  - Symbol 0, Busy=1 and Valid=1 after edge T.
  - Symbol k after edge T+k.
  - Symbol 15 and Finish=1 after edge T+15; Busy=0 after edge T+15.
  - Valid=0 and Finish=0 after edge T+16, unless a new Start was accepted at T+16.
- Start at T+16 (Busy=0 before it) begins the next burst immediately, giving back-to-back bursts with no gap.
- Minimum period between Finish pulses is 16 cycles.
- Latency from Start to first symbol is 1 cycle. From Start to Finish is 16 cycles.
- Reset=0 at any edge, including mid-burst: all outputs are 0 after that edge and no Finish is generated for the aborted burst.
- Reset releasing with Start=1 on the same edge: Start is ignored on that edge and accepted on the next edge.

## Test plan
- Polling TS1: OSType=000, LinkNumber=0, LaneNumber=00, Rate=1, Loopback=1 → symbols BC/K, F7/K, F7/K, FF, 02, 04, then 4A×10. Finish is high only in the cycle with symbol 15.
- Config TS2: OSType=001, LinkNumber=01, LaneNumber=01, Rate=3 → symbol 1 = 01 (K=0), lane 5 symbol 2 = 05, lane 15 symbol 2 = 0F, symbol 4 = 0E, symbols 6–15 = 45.
- IDLE with reserved type: OSType=100, then OSType=111 → both give 16 cycles of 00/K=0 with Valid=1, then Finish.
- Start held high continuously: bursts are contiguous, a Finish pulse every 16 cycles, and OSType changed mid-burst takes effect only on the next burst.
- Reset asserted at symbol 7 → all outputs are 0 next cycle with no Finish. After release, a new Start produces a full burst beginning at symbol 0.
- Rate sweep 1..5 with TS1 → symbol 4 = 02, 06, 0E, 1E, 3E.
